// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM state encoding,
// Booth digit select encoding and the iteration-count helper.
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } booth_state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

    // Unsigned operands need one extra digit so the zero-extended top bit is consumed.
    function automatic int unsigned booth_iter(input int unsigned width, input logic is_signed);
        return is_signed ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_radix4_digit_encoder.sv
// Maps a radix-4 Booth triplet {b[2i+1], b[2i], b[2i-1]} to the digit select
// consumed by the accumulate datapath.
module booth_radix4_digit_encoder
    import booth_mul_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_e digit
);

    always_comb begin
        digit = ZERO;
        unique case (triplet)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_multiplier_param.sv
// Iterative radix-4 Booth multiplier, WIDTH-parametrised, signed/unsigned per operation.
// Optional early termination on an exhausted multiplier: define BOOTH_EARLY_TERM_EN.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for op_start, result cleared
// EXEC  | one Booth digit accumulated per cycle, op_busy high
// DONE  | result held, op_done high, op_start restarts back-to-back
module booth_multiplier_param
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               op_busy,
    output logic               op_done,
    output logic [2*WIDTH-1:0] result
);

    localparam int EXT_W = WIDTH + 2;
    localparam int MR_W  = WIDTH + 3;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH / 2 + 2);

    localparam logic [CNT_W-1:0] LAST_S = CNT_W'(booth_iter(WIDTH, 1'b1) - 1);
    localparam logic [CNT_W-1:0] LAST_U = CNT_W'(booth_iter(WIDTH, 1'b0) - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EXEC = EXEC;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic [MR_W-1:0]  mreg;
    logic [PW-1:0]    mcand_q;

    logic [EXT_W-1:0] mult_ext;
    logic [PW-1:0]    mcand_ext;
    logic [PW-1:0]    addend;
    booth_digit_e     digit_sel;
    logic             last_iter;
    logic             early_term;

    assign mult_ext  = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
    assign mcand_ext = {{WIDTH{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};

    booth_radix4_digit_encoder u_digit_enc (
        .triplet (mreg[2:0]),
        .digit   (digit_sel)
    );

    always_comb begin
        addend = '0;
        unique case (digit_sel)
            POS1:    addend = mcand_q;
            POS2:    addend = mcand_q << 1;
            NEG1:    addend = -mcand_q;
            NEG2:    addend = -(mcand_q << 1);
            default: addend = '0;
        endcase
    end

    assign last_iter = (cnt == (mode_q ? LAST_S : LAST_U));

`ifdef BOOTH_EARLY_TERM_EN
    // Uniform remaining bits (guard included) leave only zero digits to accumulate.
    assign early_term = (&mreg) | ~(|mreg);
`else
    assign early_term = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mode_q  <= 1'b0;
            mreg    <= '0;
            mcand_q <= '0;
            result  <= '0;
        end else if (op_clear) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (op_start) begin
                        state   <= S_EXEC;
                        cnt     <= '0;
                        mode_q  <= signed_mode;
                        mreg    <= {mult_ext, 1'b0};
                        mcand_q <= mcand_ext;
                        result  <= '0;
                    end
                end
                S_EXEC: begin
                    if (early_term) begin
                        state <= S_DONE;
                    end else begin
                        result  <= result + addend;
                        mcand_q <= mcand_q << 2;
                        mreg    <= {{2{mreg[MR_W-1]}}, mreg[MR_W-1:2]};
                        cnt     <= cnt + CNT_W'(1);
                        if (last_iter)
                            state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign op_busy = (state == S_EXEC);
    assign op_done = (state == S_DONE);

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Scoreboard bench for booth_multiplier_param at WIDTH 8, 16 and 64.
// Expected latency follows BOOTH_EARLY_TERM_EN when the bench is built with it.
module tb_booth_multiplier_param;

    typedef struct {
        logic [127:0] res;
        int           lat;
        string        tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_start [3];
    logic        op_clear [3];
    logic        op_busy  [3];
    logic        op_done  [3];
    logic        signed_mode = 1'b0;
    logic [63:0] a_bus = '0;
    logic [63:0] b_bus = '0;
    logic [15:0]  res8;
    logic [31:0]  res16;
    logic [127:0] res64;

    int   checks = 0;
    int   failures = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    booth_multiplier_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start[0]), .op_clear(op_clear[0]),
        .signed_mode(signed_mode), .multiplier(a_bus[7:0]), .multiplicand(b_bus[7:0]),
        .op_busy(op_busy[0]), .op_done(op_done[0]), .result(res8));

    booth_multiplier_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start[1]), .op_clear(op_clear[1]),
        .signed_mode(signed_mode), .multiplier(a_bus[15:0]), .multiplicand(b_bus[15:0]),
        .op_busy(op_busy[1]), .op_done(op_done[1]), .result(res16));

    booth_multiplier_param #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start[2]), .op_clear(op_clear[2]),
        .signed_mode(signed_mode), .multiplier(a_bus), .multiplicand(b_bus),
        .op_busy(op_busy[2]), .op_done(op_done[2]), .result(res64));

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int sel);
        return (sel == 0) ? 8 : ((sel == 1) ? 16 : 64);
    endfunction

    function automatic logic [127:0] get_res(input int sel);
        case (sel)
            0:       return {112'b0, res8};
            1:       return {96'b0, res16};
            default: return res64;
        endcase
    endfunction

    function automatic logic [127:0] ext_op(input logic [63:0] v, input int w, input logic sgn);
        logic [127:0] r = '0;
        for (int j = 0; j < 128; j++)
            r[j] = (j < w) ? v[j] : (sgn & v[w-1]);
        return r;
    endfunction

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input int w, input logic sgn);
        logic [127:0] p = ext_op(a, w, sgn) * ext_op(b, w, sgn);
        logic [127:0] m = '0;
        for (int j = 0; j < 2 * w; j++)
            m[j] = p[j];
        return m;
    endfunction

    function automatic int ref_lat(input logic [63:0] a, input int w, input logic sgn);
        int iter = sgn ? (w / 2) : (w / 2 + 1);
`ifdef BOOTH_EARLY_TERM_EN
        logic [66:0] r = '0;
        int   nb = w + 3;
        logic all0;
        logic all1;
        for (int j = 1; j < nb; j++)
            r[j] = (j - 1 < w) ? a[j-1] : (sgn & a[w-1]);
        for (int i = 0; i < iter; i++) begin
            all0 = 1'b1;
            all1 = 1'b1;
            for (int j = 0; j < nb; j++) begin
                all0 = all0 & ~r[j];
                all1 = all1 & r[j];
            end
            if (all0 | all1)
                return i + 1;
            for (int j = 0; j < nb; j++)
                r[j] = (j + 2 < nb) ? r[j+2] : r[nb-1];
        end
`else
        if (a === 64'hx) iter = 0;
`endif
        return iter;
    endfunction

    // Runs one operation; with disturb set, new operands/mode and a start pulse
    // are presented mid-EXEC and must be ignored.
    task automatic run_op(input int sel, input logic sgn, input logic [63:0] a,
                          input logic [63:0] b, input bit disturb, input string tag);
        exp_t e;
        int   n;
        int   w = width_of(sel);
        e.res = ref_mul(a, b, w, sgn);
        e.lat = ref_lat(a, w, sgn);
        e.tag = tag;
        signed_mode = sgn;
        a_bus = a;
        b_bus = b;
        op_start[sel] = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        op_start[sel] = 1'b0;
        check_val({tag, "_busy"}, {127'b0, op_busy[sel]}, 128'd1);
        n = 0;
        while (!op_done[sel] && n < 200) begin
            if (disturb && n == 1) begin
                a_bus = ~a;
                b_bus = b ^ 64'h5555;
                signed_mode = ~sgn;
                op_start[sel] = 1'b1;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            op_start[sel] = 1'b0;
        end
        e = sb.pop_front();
        check_val({e.tag, "_lat"}, 128'(n), 128'(e.lat));
        check_val({e.tag, "_res"}, get_res(sel), e.res);
        check_val({e.tag, "_nobusy"}, {127'b0, op_busy[sel]}, 128'd0);
    endtask

    task automatic hold_check(input int sel, input logic [127:0] exp, input string tag);
        repeat (4) @(negedge clk);
        check_val({tag, "_hold_done"}, {127'b0, op_done[sel]}, 128'd1);
        check_val({tag, "_hold_res"}, get_res(sel), exp);
    endtask

    initial begin
        int seen;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rs;
        int          sel;
        for (int i = 0; i < 3; i++) begin
            op_start[i] = 1'b0;
            op_clear[i] = 1'b0;
        end

        #1;
        check_val("rst_res64", res64, 128'd0);
        check_val("rst_res8", {112'b0, res8}, 128'd0);
        check_val("rst_flags", {124'b0, op_busy[2], op_done[2], op_busy[0], op_done[0]}, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 7 x -7 at WIDTH 64, fixed expectations
        signed_mode = 1'b1;
        a_bus = 64'd7;
        b_bus = -64'sd7;
        op_start[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_start[2] = 1'b0;
        seen = 0;
        while (!op_done[2] && seen < 200) begin
            @(posedge clk);
            seen++;
            @(negedge clk);
        end
`ifdef BOOTH_EARLY_TERM_EN
        check_val("m7x7_lat", 128'(seen), 128'd3);
`else
        check_val("m7x7_lat", 128'(seen), 128'd32);
`endif
        check_val("m7x7_res", res64, {{120{1'b1}}, 8'hCF});
        hold_check(2, {{120{1'b1}}, 8'hCF}, "m7x7");

        run_op(0, 1'b0, 64'hFF, 64'hFF, 1'b0, "u8_ff_ff");
        check_val("u8_ff_ff_const", {112'b0, res8}, 128'h0000_FE01);
        run_op(0, 1'b1, 64'h80, 64'h80, 1'b0, "s8_80_80");
        check_val("s8_80_80_const", {112'b0, res8}, 128'h4000);
        run_op(0, 1'b1, 64'hFF, 64'h01, 1'b0, "s8_ff_01");
        check_val("s8_ff_01_const", {112'b0, res8}, 128'hFFFF);
        run_op(1, 1'b1, 64'h8000, 64'h7FFF, 1'b0, "s16_min_max");

        // operand/start changes mid-EXEC are ignored, then back-to-back from DONE
        run_op(2, 1'b1, 64'd7, -64'sd7, 1'b1, "disturb");
        run_op(2, 1'b1, 64'd3, 64'd5, 1'b0, "b2b_3x5");
        check_val("b2b_3x5_const", res64, 128'd15);

        // clear three cycles into EXEC
        signed_mode = 1'b1;
        a_bus = 64'd7;
        b_bus = -64'sd7;
        op_start[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_start[2] = 1'b0;
        repeat (3) @(negedge clk);
        op_clear[2] = 1'b1;
        @(negedge clk);
        op_clear[2] = 1'b0;
        check_val("clr_busy", {127'b0, op_busy[2]}, 128'd0);
        check_val("clr_res", res64, 128'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (op_done[2]) seen++;
        end
        check_val("clr_never_done", 128'(seen), 128'd0);
        run_op(2, 1'b0, 64'd2, 64'd3, 1'b0, "post_clr_2x3");
        check_val("post_clr_2x3_const", res64, 128'd6);

        // asynchronous reset mid-EXEC
        signed_mode = 1'b1;
        a_bus = 64'h1234_5678_9ABC_DEF1;
        b_bus = 64'hFEDC_BA98_7654_3211;
        op_start[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_start[2] = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_res", res64, 128'd0);
        check_val("arst_flags", {126'b0, op_busy[2], op_done[2]}, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        op_start[2] = 1'b1;
        op_clear[2] = 1'b1;
        @(negedge clk);
        op_start[2] = 1'b0;
        op_clear[2] = 1'b0;
        check_val("clr_wins_flags", {126'b0, op_busy[2], op_done[2]}, 128'd0);
        @(negedge clk);
        check_val("clr_wins_idle", {126'b0, op_busy[2], op_done[2]}, 128'd0);

        // random regression
        for (int i = 0; i < 1000; i++) begin
            sel = i % 3;
            rs = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 7 == 0) ra = 64'($urandom_range(0, 15));
            if (i % 11 == 0) ra = ~64'($urandom_range(0, 15));
            if (i % 13 == 0) rb = '1;
            run_op(sel, rs, ra, rb, 1'b0, $sformatf("rnd%0d_w%0d", i, width_of(sel)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
